cve2_multdiv_arb: RTL
=====================

CVE2_MULTDIV_ARB -- requirements
Module: cve2_multdiv_arb

Interface
REQ-001 Parameter: TimeoutCycles, default 40, max cycles from issue to valid_i before the watchdog fires.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  in  1  reset; synchronous and active-low.
REQ-004 req_i  in  2  per-requester operation request; index 0 = core, index 1 = auxiliary.
REQ-005 operator_i  in  2x2  per-requester op: 0 MUL, 1 MULH, 2 DIV, 3 REM.
REQ-006 signed_mode_i  in  2x2  per-requester signedness: bit0 = op A, bit1 = op B.
REQ-007 op_a_i / op_b_i  in  2x32  per-requester operands.
REQ-008 gnt_o  out  2  one-hot grant pulse; operands are latched in that cycle.
REQ-009 rvalid_o  out  2  one-cycle result-valid pulse to the owning requester.
REQ-010 result_o  out  32  result; shared by both requesters, qualified by rvalid_o.
REQ-011 flush_i  in  2  per-requester abort of the pending operation.
REQ-012 mult_en_o, div_en_o, mult_sel_o, div_sel_o  out  1 each  drive the slow mult/div unit.
REQ-013 operator_o, signed_mode_o  out  2 each  latched operation and signedness, to the unit.
REQ-014 op_a_o, op_b_o  out  32 each  latched operands, to the unit.
REQ-015 multdiv_ready_id_o  out  1  ready to the unit.
REQ-016 valid_i, result_i  in  1 / 32  completion flag and result from the unit.
REQ-017 busy_o  out  1  unit owned; timeout_o  out  1  sticky watchdog error.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DRAIN; reset state IDLE.
REQ-019 IDLE, any req_i set: grant one requester by round-robin, latch its op and operands, pulse gnt_o, go to ISSUE.
REQ-020 Round-robin: priority pointer moves to the non-granted index after each grant; after reset, index 0 has priority.
REQ-021 Single request: granted in the same cycle it is seen in IDLE, regardless of the pointer.
REQ-022 ISSUE and WAIT: mult_en_o = mult_sel_o = (op<2); div_en_o = div_sel_o = (op>=2); multdiv_ready_id_o = 1.
REQ-023 ISSUE lasts exactly one cycle, then WAIT.
REQ-024 WAIT, valid_i=1: capture result_i into result_o, pulse rvalid_o[owner], clear all enables next cycle, return to IDLE.
REQ-025 Grant-to-rvalid latency = unit latency + 1 cycle; no new grant is made in the rvalid cycle.
REQ-026 flush_i[owner] in ISSUE/WAIT: set discard flag; the unit keeps enabled until valid_i, since it only returns to its idle state on completion.
REQ-027 Discarded completion: no rvalid_o, result_o unchanged.
REQ-028 flush_i of a non-owner: ignored.
REQ-029 flush_i coincident with valid_i: completion is discarded.
REQ-030 Watchdog counts WAIT cycles; reaching TimeoutCycles sets timeout_o and forces DRAIN.
REQ-031 DRAIN: enables held until valid_i, then IDLE with no rvalid_o.
REQ-032 timeout_o clears only on reset.
REQ-033 Requester deasserting req_i after gnt_o: no effect on the in-flight operation.
REQ-034 busy_o = (state != IDLE).

Reset
REQ-035 In any cycle with rst_ni=0 at the clock edge, all of the following take their reset values: state IDLE, pointer 0, discard 0, counter 0, timeout_o 0, result_o 0, all enables/gnt/rvalid 0, latched op/operands 0.
REQ-036 Reset mid-operation abandons the operation with no rvalid_o; the system reset also resets the unit.

Structure
REQ-037 Shared package holds the operator enum (MUL/MULH/DIV/REM), the FSM state enum and the requester-count constant (2).
REQ-038 One sub-module is natural: cve2_rr_arb2 (2-way round-robin grant with pointer).

Verification
REQ-039 Core MUL 7x6, unit returns valid_i 4 cycles after ISSUE -> gnt_o=01; rvalid_o[0] 5 cycles after grant; result_o=42.
REQ-040 Both req_i high in IDLE after reset -> grant 01 first, then 10; next simultaneous request -> 01.
REQ-041 Aux DIV, flush_i[1] 3 cycles into WAIT -> enables held until valid_i; no rvalid_o; result_o unchanged; IDLE the following cycle.
REQ-042 TimeoutCycles=8, valid_i withheld -> timeout_o=1 at WAIT cycle 8; DRAIN; late valid_i -> IDLE, no rvalid_o.
REQ-043 rst_ni=0 during WAIT -> next cycle busy_o=0, all outputs 0, pointer favours requester 0.
REQ-044 Same-cycle flush_i[owner] and valid_i -> no rvalid_o.

Source files
------------

// File: rtl/cve2_multdiv_arb_pkg.sv
// Shared definitions for the two-requester mult/div arbiter.
//   NUM_REQ     : number of requesters sharing the unit (core = 0, auxiliary = 1)
//   md_op_e     : operation encoding forwarded to the mult/div unit
//   arb_state_e : arbiter FSM state, also exported as a debug output
//   md_is_div() : classifies an operation as divider-side (DIV/REM)
package cve2_multdiv_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        MD_OP_MUL  = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op >= MD_OP_DIV;
    endfunction

endpackage

// File: rtl/cve2_multdiv_arb_if.sv
// Requester-side bundle of the mult/div arbiter.
//   req_i, operator_i, signed_mode_i, op_a_i, op_b_i, flush_i : requester -> arbiter
//   gnt_o, rvalid_o, result_o                                  : arbiter -> requester
// Handshake: a requester holds req_i with its operation fields stable until it
// sees gnt_o[idx]; the fields are captured at the clock edge that raises gnt_o,
// after which req_i may drop without effect. Exactly one rvalid_o[idx] pulse
// later qualifies result_o, unless the operation was flushed, timed out or reset.
interface cve2_multdiv_arb_if;
    import cve2_multdiv_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0][1:0]   operator_i;
    logic [NUM_REQ-1:0][1:0]   signed_mode_i;
    logic [NUM_REQ-1:0][31:0]  op_a_i;
    logic [NUM_REQ-1:0][31:0]  op_b_i;
    logic [NUM_REQ-1:0]        flush_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        rvalid_o;
    logic [31:0]               result_o;

    modport master (
        output req_i, operator_i, signed_mode_i, op_a_i, op_b_i, flush_i,
        input  gnt_o, rvalid_o, result_o
    );

    modport slave (
        input  req_i, operator_i, signed_mode_i, op_a_i, op_b_i, flush_i,
        output gnt_o, rvalid_o, result_o
    );

endinterface

// File: rtl/cve2_rr_arb2.sv
// Two-way round-robin grant selector.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   req           : request vector
//   advance       : a grant from gnt is being taken this cycle
//   gnt           : combinational one-hot grant (zero when nothing requests)
//   ptr           : requester currently holding priority on a tie
module cve2_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr
);

    logic ptr_q;

    // A lone request wins regardless of the pointer; the pointer only breaks ties.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After a grant, priority passes to the index that was not granted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_q <= gnt[0];
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/cve2_multdiv_arb.sv
// Arbitrates the core and an auxiliary requester onto one slow mult/div unit.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   req_if (slave)         : requester bundle (requests, operands, flush, grant, rvalid, result)
//   mult_en_o/mult_sel_o   : multiplier enable/select while an operation is owned
//   div_en_o/div_sel_o     : divider enable/select while an operation is owned
//   operator_o, signed_mode_o, op_a_o, op_b_o : operation latched at grant
//   multdiv_ready_id_o     : ready to the unit while an operation is owned
//   valid_i, result_i      : completion from the unit
//   busy_o                 : unit owned (FSM not idle)
//   timeout_o              : sticky watchdog error, cleared only by reset
//   state, rr_ptr          : debug view of FSM state and round-robin pointer
module cve2_multdiv_arb
    import cve2_multdiv_arb_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 40
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    cve2_multdiv_arb_if.slave   req_if,
    output logic                mult_en_o,
    output logic                div_en_o,
    output logic                mult_sel_o,
    output logic                div_sel_o,
    output logic [1:0]          operator_o,
    output logic [1:0]          signed_mode_o,
    output logic [31:0]         op_a_o,
    output logic [31:0]         op_b_o,
    output logic                multdiv_ready_id_o,
    input  logic                valid_i,
    input  logic [31:0]         result_i,
    output logic                busy_o,
    output logic                timeout_o,
    output arb_state_e          state,
    output logic                rr_ptr
);

    // TimeoutCycles must be at least 1.
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    arb_state_e        state_q;
    logic              owner_q;
    logic              discard_q;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_nxt;
    logic              timeout_q;
    logic [31:0]       result_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rvalid_q;
    logic [1:0]        operator_q;
    logic [1:0]        signed_mode_q;
    logic [31:0]       op_a_q;
    logic [31:0]       op_b_q;

    logic [1:0]        rr_gnt;
    logic              grant_idx;
    logic              take_grant;
    logic              owner_flush;

    assign take_grant  = (state_q == ST_IDLE) && (rr_gnt != 2'b00);
    assign grant_idx   = rr_gnt[1];
    assign owner_flush = req_if.flush_i[owner_q];
    assign cnt_nxt     = cnt_q + CntW'(1);

    cve2_rr_arb2 u_rr_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (req_if.req_i),
        .advance (take_grant),
        .gnt     (rr_gnt),
        .ptr     (rr_ptr)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            discard_q     <= 1'b0;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
            result_q      <= '0;
            gnt_q         <= '0;
            rvalid_q      <= '0;
            operator_q    <= '0;
            signed_mode_q <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (take_grant) begin
                        gnt_q         <= rr_gnt;
                        owner_q       <= grant_idx;
                        operator_q    <= req_if.operator_i[grant_idx];
                        signed_mode_q <= req_if.signed_mode_i[grant_idx];
                        op_a_q        <= req_if.op_a_i[grant_idx];
                        op_b_q        <= req_if.op_b_i[grant_idx];
                        discard_q     <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (owner_flush) begin
                        discard_q <= 1'b1;
                    end
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (valid_i) begin
                        // A flush arriving together with the completion still discards it.
                        if (!discard_q && !owner_flush) begin
                            result_q          <= result_i;
                            rvalid_q[owner_q] <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end else begin
                        if (owner_flush) begin
                            discard_q <= 1'b1;
                        end
                        cnt_q <= cnt_nxt;
                        if (cnt_nxt == CntW'(TimeoutCycles)) begin
                            timeout_q <= 1'b1;
                            state_q   <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The unit only returns to idle on completion, so keep it enabled until then.
                    if (valid_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Enables are decoded from registered state, so they hold from ISSUE until
    // the cycle after valid_i, including while draining a discarded operation.
    assign busy_o             = (state_q != ST_IDLE);
    assign mult_en_o          = busy_o && !md_is_div(operator_q);
    assign mult_sel_o         = mult_en_o;
    assign div_en_o           = busy_o && md_is_div(operator_q);
    assign div_sel_o          = div_en_o;
    assign multdiv_ready_id_o = busy_o;

    assign operator_o    = operator_q;
    assign signed_mode_o = signed_mode_q;
    assign op_a_o        = op_a_q;
    assign op_b_o        = op_b_q;
    assign timeout_o     = timeout_q;
    assign state         = state_q;

    assign req_if.gnt_o    = gnt_q;
    assign req_if.rvalid_o = rvalid_q;
    assign req_if.result_o = result_q;

endmodule
